// File: rtl/jstk_poller_pkg.sv
// rtl/jstk_poller_pkg.sv - shared constants, decode positions and FSM states for jstk_poller
package jstk_poller_pkg;

    localparam logic [5:0] JSTK_CMD_LED   = 6'b100000;
    localparam int         CENTER_DEFAULT = 512;

    // Byte/bit positions of the fields inside the 40-bit PmodJSTK response
    localparam int X_LO_MSB = 39;
    localparam int X_LO_LSB = 32;
    localparam int X_HI_MSB = 25;
    localparam int X_HI_LSB = 24;
    localparam int Y_LO_MSB = 23;
    localparam int Y_LO_LSB = 16;
    localparam int Y_HI_MSB = 9;
    localparam int Y_HI_LSB = 8;
    localparam int BTN_MSB  = 2;
    localparam int BTN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } jstk_state_e;

    function automatic logic [7:0] jstk_cmd_byte(input logic [1:0] led);
        return {JSTK_CMD_LED, led};
    endfunction

endpackage

// File: rtl/jstk_poller_if.sv
// rtl/jstk_poller_if.sv - joystick-side and game-side signal bundle for jstk_poller
interface jstk_poller_if;
    logic        enable;
    logic [1:0]  led_cmd;
    logic        sndRec;
    logic [7:0]  DIN;
    logic [39:0] jstk_data;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        dir_up;
    logic        dir_down;
    logic [2:0]  btn;
    logic [2:0]  btn_press;
    logic        sample_valid;

    modport master (
        input  enable, led_cmd, jstk_data,
        output sndRec, DIN, pos_x, pos_y, dir_up, dir_down, btn, btn_press, sample_valid
    );

    modport slave (
        output enable, led_cmd, jstk_data,
        input  sndRec, DIN, pos_x, pos_y, dir_up, dir_down, btn, btn_press, sample_valid
    );
endinterface

// File: rtl/jstk_poller_avg4.sv
// rtl/jstk_poller_avg4.sv - jstk_avg4: mean of the incoming sample and the three previous captures
module jstk_avg4 #(
    parameter int CENTER = 512
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       shift_en,
    input  logic [9:0] sample_in,
    output logic [9:0] avg_out
);
    localparam logic [9:0] CENTER_POS = 10'(CENTER);

    logic [2:0][9:0] hist_q;
    logic [2:0][9:0] hist_d;
    logic [11:0]     sum;

    // The window is the sample being captured plus the three held ones, so the
    // averaged value is ready in the same cycle the raw sample is captured.
    assign sum     = 12'(sample_in) + 12'(hist_q[0]) + 12'(hist_q[1]) + 12'(hist_q[2]);
    assign avg_out = 10'(sum >> 2);

    always_comb begin
        hist_d = hist_q;
        if (shift_en) begin
            hist_d = {hist_q[1:0], sample_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= {3{CENTER_POS}};
        end else begin
            hist_q <= hist_d;
        end
    end
endmodule

// File: rtl/jstk_poller.sv
// rtl/jstk_poller.sv - periodic PmodJSTK poller and decoder; JSTK_AVG_EN enables 4-sample position averaging
module jstk_poller
    import jstk_poller_pkg::*;
#(
    parameter int POLL_CYCLES = 125000,
    parameter int REQ_CYCLES  = 4096,
    parameter int XFER_CYCLES = 8192,
    parameter int CENTER      = CENTER_DEFAULT,
    parameter int DEADZONE    = 64
) (
    input logic           clk,
    input logic           reset,
    jstk_poller_if.master bus
);
    localparam int STATE_MAX = (REQ_CYCLES > XFER_CYCLES) ? REQ_CYCLES : XFER_CYCLES;
    localparam int POLL_W    = $clog2(POLL_CYCLES);
    localparam int CNT_W     = $clog2(STATE_MAX + 1);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REQ_LAST   = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0]  XFER_LAST  = CNT_W'(XFER_CYCLES - 1);
    localparam logic [10:0]       UP_TH      = 11'(CENTER + DEADZONE);
    localparam logic [10:0]       DN_TH      = 11'(CENTER - DEADZONE);
    localparam logic [9:0]        CENTER_POS = 10'(CENTER);

    jstk_state_e       state_q, state_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
    logic              snd_rec_q, snd_rec_d;
    logic [7:0]        din_q, din_d;
    logic [9:0]        pos_x_q, pos_x_d;
    logic [9:0]        pos_y_q, pos_y_d;
    logic              dir_up_q, dir_up_d;
    logic              dir_down_q, dir_down_d;
    logic [2:0]        btn_q, btn_d;
    logic [2:0]        btn_press_q, btn_press_d;
    logic              valid_q, valid_d;

    logic [9:0] raw_x, raw_y, new_x, new_y;
    logic [2:0] raw_b;
    logic       capture;
    logic       unused_jstk_bits;

    assign raw_x   = {bus.jstk_data[X_HI_MSB:X_HI_LSB], bus.jstk_data[X_LO_MSB:X_LO_LSB]};
    assign raw_y   = {bus.jstk_data[Y_HI_MSB:Y_HI_LSB], bus.jstk_data[Y_LO_MSB:Y_LO_LSB]};
    assign raw_b   = bus.jstk_data[BTN_MSB:BTN_LSB];
    assign capture = (state_q == ST_CAPTURE);

    assign unused_jstk_bits = ^{bus.jstk_data[31:26], bus.jstk_data[15:10], bus.jstk_data[7:3]};

`ifdef JSTK_AVG_EN
    jstk_avg4 #(.CENTER(CENTER)) u_avg_x (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (capture),
        .sample_in (raw_x),
        .avg_out   (new_x)
    );

    jstk_avg4 #(.CENTER(CENTER)) u_avg_y (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (capture),
        .sample_in (raw_y),
        .avg_out   (new_y)
    );
`else
    assign new_x = raw_x;
    assign new_y = raw_y;
`endif

    always_comb begin
        state_d     = state_q;
        st_cnt_d    = st_cnt_q;
        din_d       = jstk_cmd_byte(bus.led_cmd);
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_up_d    = dir_up_q;
        dir_down_d  = dir_down_q;
        btn_d       = btn_q;
        btn_press_d = 3'b000;
        valid_d     = 1'b0;
        // Free-running through REQ/WAIT keeps the request period fixed; it
        // saturates so a disabled poller restarts one cycle after enable.
        poll_cnt_d  = (poll_cnt_q == POLL_LAST) ? poll_cnt_q : poll_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (poll_cnt_q == POLL_LAST && bus.enable) begin
                    poll_cnt_d = '0;
                    st_cnt_d   = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                st_cnt_d = st_cnt_q + 1'b1;
                if (st_cnt_q == REQ_LAST) begin
                    st_cnt_d = '0;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                st_cnt_d = st_cnt_q + 1'b1;
                if (st_cnt_q == XFER_LAST) begin
                    st_cnt_d = '0;
                    state_d  = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                pos_x_d     = new_x;
                pos_y_d     = new_y;
                dir_up_d    = {1'b0, new_y} > UP_TH;
                dir_down_d  = {1'b0, new_y} < DN_TH;
                btn_d       = raw_b;
                btn_press_d = raw_b & ~btn_q;
                valid_d     = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        snd_rec_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            poll_cnt_q  <= '0;
            st_cnt_q    <= '0;
            snd_rec_q   <= 1'b0;
            din_q       <= jstk_cmd_byte(2'b00);
            pos_x_q     <= CENTER_POS;
            pos_y_q     <= CENTER_POS;
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
            btn_q       <= 3'b000;
            btn_press_q <= 3'b000;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            poll_cnt_q  <= poll_cnt_d;
            st_cnt_q    <= st_cnt_d;
            snd_rec_q   <= snd_rec_d;
            din_q       <= din_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_up_q    <= dir_up_d;
            dir_down_q  <= dir_down_d;
            btn_q       <= btn_d;
            btn_press_q <= btn_press_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.sndRec       = snd_rec_q;
    assign bus.DIN          = din_q;
    assign bus.pos_x        = pos_x_q;
    assign bus.pos_y        = pos_y_q;
    assign bus.dir_up       = dir_up_q;
    assign bus.dir_down     = dir_down_q;
    assign bus.btn          = btn_q;
    assign bus.btn_press    = btn_press_q;
    assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_jstk_poller.sv
// tb/tb_jstk_poller.sv - directed and randomized self-checking bench for jstk_poller
`timescale 1ns/1ps
module tb_jstk_poller;
    localparam int POLL   = 64;
    localparam int REQ    = 4;
    localparam int XFER   = 8;
    localparam int CENTER = 512;
    localparam int DZ     = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jstk_poller_if bus ();

    jstk_poller #(
        .POLL_CYCLES (POLL),
        .REQ_CYCLES  (REQ),
        .XFER_CYCLES (XFER),
        .CENTER      (CENTER),
        .DEADZONE    (DZ)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int vectors    = 0;
    int miscompares = 0;

    int         hx[4];
    int         hy[4];
    int         cur_x, cur_y;
    logic [2:0] cur_b;
    logic [2:0] prev_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hx[i] = CENTER;
            hy[i] = CENTER;
        end
        prev_b = 3'b000;
    endtask

    task automatic set_data(input int x, input int y, input logic [2:0] b);
        logic [63:0] filler;
        logic [39:0] d;
        logic [9:0]  xv, yv;
        filler  = {$urandom, $urandom};
        d       = filler[39:0];
        xv      = 10'(x);
        yv      = 10'(y);
        d[39:32] = xv[7:0];
        d[25:24] = xv[9:8];
        d[23:16] = yv[7:0];
        d[9:8]   = yv[9:8];
        d[2:0]   = b;
        bus.jstk_data = d;
        cur_x = x;
        cur_y = y;
        cur_b = b;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.sample_valid !== 1'b1 && n < 400);
        check("valid_timeout", {31'b0, bus.sample_valid}, 32'd1);
    endtask

    task automatic expect_sample(input string tag);
        int n, ex, ey;
        logic [2:0] ep;
        wait_valid(n);
        for (int i = 3; i > 0; i--) begin
            hx[i] = hx[i-1];
            hy[i] = hy[i-1];
        end
        hx[0] = cur_x;
        hy[0] = cur_y;
`ifdef JSTK_AVG_EN
        ex = (hx[0] + hx[1] + hx[2] + hx[3]) / 4;
        ey = (hy[0] + hy[1] + hy[2] + hy[3]) / 4;
`else
        ex = cur_x;
        ey = cur_y;
`endif
        ep     = cur_b & ~prev_b;
        prev_b = cur_b;
        check({tag, "_pos_x"}, {22'b0, bus.pos_x}, 32'(ex));
        check({tag, "_pos_y"}, {22'b0, bus.pos_y}, 32'(ey));
        check({tag, "_dir_up"}, {31'b0, bus.dir_up}, (ey > CENTER + DZ) ? 32'd1 : 32'd0);
        check({tag, "_dir_down"}, {31'b0, bus.dir_down}, (ey < CENTER - DZ) ? 32'd1 : 32'd0);
        check({tag, "_btn"}, {29'b0, bus.btn}, {29'b0, cur_b});
        check({tag, "_btn_press"}, {29'b0, bus.btn_press}, {29'b0, ep});
        @(negedge clk);
        check({tag, "_press_clear"}, {29'b0, bus.btn_press}, 32'd0);
        check({tag, "_valid_clear"}, {31'b0, bus.sample_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sndrec"}, {31'b0, bus.sndRec}, 32'd0);
        check({tag, "_din"}, {24'b0, bus.DIN}, 32'h80);
        check({tag, "_pos_x"}, {22'b0, bus.pos_x}, 32'(CENTER));
        check({tag, "_pos_y"}, {22'b0, bus.pos_y}, 32'(CENTER));
        check({tag, "_dirs"}, {30'b0, bus.dir_up, bus.dir_down}, 32'd0);
        check({tag, "_btn"}, {29'b0, bus.btn}, 32'd0);
        check({tag, "_press"}, {29'b0, bus.btn_press}, 32'd0);
        check({tag, "_valid"}, {31'b0, bus.sample_valid}, 32'd0);
    endtask

    int dir_x[8] = '{1023, 5,   6,   7,   8,   0,    300, 700};
    int dir_y[8] = '{0,    576, 577, 448, 447, 1023, 512, 513};
    int dir_b[8] = '{0,    5,   5,   7,   7,   2,    0,   4};

    initial begin
        int t, t_r1, t_f1, t_v, t_r2, n, highs;
        logic prev_snd;
        logic [1:0] led;

        reset = 1'b1;
        bus.enable = 1'b0;
        bus.led_cmd = 2'b00;
        bus.jstk_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Request timing: 4 cycles high, 64-cycle period, sample 13 cycles after rise
        set_data(CENTER, CENTER, 3'b000);
        bus.enable = 1'b1;
        reset = 1'b0;
        t_r1 = -1; t_f1 = -1; t_v = -1; t_r2 = -1;
        prev_snd = 1'b0;
        for (t = 1; t <= 200 && t_r2 < 0; t++) begin
            @(negedge clk);
            if (bus.sndRec === 1'b1 && prev_snd === 1'b0) begin
                if (t_r1 < 0) t_r1 = t;
                else t_r2 = t;
            end
            if (bus.sndRec === 1'b0 && prev_snd === 1'b1 && t_f1 < 0) t_f1 = t;
            if (bus.sample_valid === 1'b1 && t_v < 0) t_v = t;
            prev_snd = bus.sndRec;
        end
        check("first_req", 32'(t_r1), 32'(POLL));
        check("req_width", 32'(t_f1 - t_r1), 32'(REQ));
        check("valid_latency", 32'(t_v - t_r1), 32'(REQ + XFER + 1));
        check("poll_period", 32'(t_r2 - t_r1), 32'(POLL));

        // Directed boundary vectors then random ones; DIN tracks led_cmd
        for (int i = 0; i < 8; i++) begin
            set_data(dir_x[i], dir_y[i], 3'(dir_b[i]));
            expect_sample("directed");
            led = 2'($urandom_range(3, 0));
            bus.led_cmd = led;
            @(negedge clk);
            check("din", {24'b0, bus.DIN}, 32'h80 | 32'(led));
        end
        for (int i = 0; i < 12; i++) begin
            set_data($urandom_range(1023, 0), $urandom_range(1023, 0), 3'($urandom_range(7, 0)));
            expect_sample("random");
        end

        // enable drops mid-transaction: sample completes, no further request
        set_data($urandom_range(1023, 0), $urandom_range(1023, 0), 3'($urandom_range(7, 0)));
        n = 0;
        do begin @(negedge clk); n++; end while (bus.sndRec !== 1'b1 && n < 200);
        check("snd_rise_timeout", {31'b0, bus.sndRec}, 32'd1);
        repeat (REQ + 2) @(negedge clk);
        bus.enable = 1'b0;
        expect_sample("en_fall");
        highs = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.sndRec !== 1'b0) highs++;
        end
        check("disabled_no_req", 32'(highs), 32'd0);
        set_data($urandom_range(1023, 0), $urandom_range(1023, 0), 3'($urandom_range(7, 0)));
        bus.enable = 1'b1;
        @(negedge clk);
        check("restart_next_cycle", {31'b0, bus.sndRec}, 32'd1);
        expect_sample("restart");

        // Reset during REQ
        n = 0;
        do begin @(negedge clk); n++; end while (bus.sndRec !== 1'b1 && n < 200);
        check("snd_rise2_timeout", {31'b0, bus.sndRec}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_req_reset");
        model_reset();
        set_data(CENTER, 1000, 3'b011);
        reset = 1'b0;
        wait_valid(n);
        check("post_reset_first_sample", 32'(n), 32'(POLL + REQ + XFER + 1));
        // That sample is consumed above; replay it through the model.
        for (int i = 3; i > 0; i--) begin hx[i] = hx[i-1]; hy[i] = hy[i-1]; end
        hx[0] = cur_x; hy[0] = cur_y; prev_b = cur_b;
`ifdef JSTK_AVG_EN
        check("avg_first", {22'b0, bus.pos_y}, 32'd634);
`else
        check("raw_first", {22'b0, bus.pos_y}, 32'd1000);
`endif

        // Three more Y=1000 samples (averaged build walks 756, 878, 1000)
        for (int i = 0; i < 3; i++) begin
            set_data(CENTER, 1000, 3'b011);
            expect_sample("y1000");
        end
        check("y1000_final", {22'b0, bus.pos_y}, 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
